// File: rtl/multi_ch_burst_gen.sv
`timescale 1ns/1ps
// Purpose : round-robin multi-channel (start_addr, length) request engine emitting data-width beats with byte strobes.
// Latency : request handshake in cycle N -> first beat_valid in cycle N+1; one idle (grant) cycle between bursts.
// Backpr. : beat_* held stable while beat_valid && !beat_ready; req_ready held low for the whole burst.
//
// Optional feature macro: ZERO_LEN_ERR_EN -- when defined, a zero-length grant pulses err for one cycle
// (the cycle after the handshake); when undefined, zero-length requests are consumed silently and err is 0.
//
// Ports:
//   clk, rstn                 clock (rising edge) and async active-low reset
//   req_valid/req_ready       per-channel request handshake; req_ready is one-hot or zero
//   req_addr/req_len          packed per-channel start byte address / length in bytes
//   beat_valid/beat_ready     beat handshake
//   beat_addr/strb/last/ch    beat byte address, contiguous byte enables, final-beat flag, owning channel
//   busy                      burst in progress
//   err                       zero-length request pulse (feature-gated)

module multi_ch_burst_gen #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    localparam int BPB   = DATA_W / 8,
    localparam int OFS_W = (BPB > 1) ? $clog2(BPB) : 1,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LEN_W-1:0]  req_len,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ADDR_W-1:0]        beat_addr,
    output logic [BPB-1:0]           beat_strb,
    output logic                     beat_last,
    output logic [CH_W-1:0]          beat_ch,
    output logic                     busy,
    output logic                     err
);

    typedef enum logic {IDLE, RUN} state_t;

    // Per-beat figures derived from the byte offset and remaining length.
    typedef struct packed {
        logic [BPB-1:0]   strb;
        logic             last;
        logic [LEN_W-1:0] n;
    } beat_calc_t;

    function automatic beat_calc_t calc_beat(input logic [OFS_W-1:0] ofs,
                                             input logic [LEN_W-1:0] rem);
        beat_calc_t res;
        int off;
        int room;
        int cnt;
        // Mask keeps BPB==1 correct, where OFS_W is padded to one bit.
        off      = int'(ofs) & (BPB - 1);
        room     = BPB - off;
        res.last = ({1'b0, rem} <= (LEN_W+1)'(room));
        cnt      = res.last ? int'(rem) : room;
        res.n    = LEN_W'(cnt);
        res.strb = '0;
        for (int b = 0; b < BPB; b++) begin
            res.strb[b] = (b >= off) && (b < off + cnt);
        end
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [CH_W-1:0]    rr_q, ch_q, gnt_idx, rr_next;
    logic               gnt_vld;
    logic [NUM_CH-1:0]  gnt_oh;
    logic [ADDR_W-1:0]  sel_addr, addr_q, next_addr;
    logic [LEN_W-1:0]   sel_len, rem_q, n_q, rem_next;
    logic [BPB-1:0]     strb_q;
    logic               last_q;
    logic               grant, beat_hs;
    int                 cand_dist, best_dist;
    beat_calc_t         first_calc, next_calc;

    // Round-robin pick: the valid channel at the smallest wrapped distance from rr_q wins.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_len   = '0;
        best_dist = NUM_CH;
        cand_dist = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            cand_dist = j - int'(rr_q);
            if (cand_dist < 0) cand_dist = cand_dist + NUM_CH;
            if (req_valid[j] && (cand_dist < best_dist)) begin
                best_dist = cand_dist;
                gnt_vld   = 1'b1;
                gnt_idx   = CH_W'(j);
                sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                sel_len   = req_len[j*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            gnt_oh[j] = gnt_vld && (gnt_idx == CH_W'(j));
        end
    end

    assign rr_next    = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
    assign grant      = (state_q == IDLE) && gnt_vld;
    assign beat_hs    = (state_q == RUN) && beat_ready;
    // After the first beat every beat starts on a data-width boundary; address wraps naturally.
    assign next_addr  = (addr_q & ~ADDR_W'(BPB - 1)) + ADDR_W'(BPB);
    assign rem_next   = rem_q - n_q;
    assign first_calc = calc_beat(sel_addr[OFS_W-1:0], sel_len);
    assign next_calc  = calc_beat(next_addr[OFS_W-1:0], rem_next);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt_oh;
                // Zero-length grants are consumed in place; no beats follow.
                if (gnt_vld && (sel_len != '0)) state_d = RUN;
            end
            RUN: begin
                if (beat_ready && last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q   <= '0;
            ch_q   <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            n_q    <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
        end else if (grant) begin
            rr_q   <= rr_next;
            ch_q   <= gnt_idx;
            addr_q <= sel_addr;
            rem_q  <= sel_len;
            n_q    <= first_calc.n;
            strb_q <= first_calc.strb;
            last_q <= first_calc.last;
        end else if (beat_hs) begin
            addr_q <= next_addr;
            rem_q  <= rem_next;
            n_q    <= next_calc.n;
            strb_q <= next_calc.strb;
            last_q <= next_calc.last;
        end
    end

`ifdef ZERO_LEN_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= grant && (sel_len == '0);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign beat_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign beat_addr  = addr_q;
    assign beat_strb  = strb_q;
    assign beat_last  = last_q;
    assign beat_ch    = ch_q;

endmodule

// File: tb/tb_multi_ch_burst_gen.sv
`timescale 1ns/1ps
// Bench for multi_ch_burst_gen: queued per-channel request sources, random beat_ready, and a byte-level
// reference model whose expected beats are scored by an independent negedge monitor.

module tb_multi_ch_burst_gen;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [NUM_CH-1:0]        req_valid = '0;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
    logic [NUM_CH*LEN_W-1:0]  req_len = '0;
    logic                     beat_valid;
    logic                     beat_ready = 1'b0;
    logic [ADDR_W-1:0]        beat_addr;
    logic [3:0]               beat_strb;
    logic                     beat_last;
    logic [1:0]               beat_ch;
    logic                     busy;
    logic                     err;

    always #5 clk = ~clk;

    multi_ch_burst_gen #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_addr(beat_addr), .beat_strb(beat_strb), .beat_last(beat_last),
        .beat_ch(beat_ch), .busy(busy), .err(err)
    );

    typedef struct packed { logic [31:0] a; logic [15:0] l; } req_t;
    typedef struct packed { logic [31:0] addr; logic [3:0] strb; logic last; logic [1:0] ch; } beat_t;

    req_t  rq [NUM_CH][$];
    beat_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   rr_m = 0;
    int   beat_cnt = 0;
    int   timeouts = 0;
    logic [3:0] hs_mask = '0;
    logic err_pend = 1'b0;
    logic done = 1'b0;
    logic br_rand = 1'b0;
    logic br_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Round-robin reference: first valid channel at or after the pointer.
    function automatic int pick(input logic [3:0] v, input int rr);
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[(rr + i) % NUM_CH]) return (rr + i) % NUM_CH;
        end
        return 0;
    endfunction

    // Walk the request byte by byte; bytes sharing a 4-byte word form one beat.
    task automatic push_beats(input int ch, input logic [31:0] a, input logic [15:0] l);
        beat_t       cur;
        logic [31:0] ba, word, cur_word;
        cur = '0;
        cur_word = '0;
        if (l == 16'd0) return;
        for (int k = 0; k < int'(l); k++) begin
            ba   = a + 32'(k);
            word = ba & ~32'h3;
            if (k == 0 || word != cur_word) begin
                if (k != 0) exp_q.push_back(cur);
                cur.addr = ba;
                cur.strb = 4'h0;
                cur.last = 1'b0;
                cur.ch   = 2'(ch);
                cur_word = word;
            end
            cur.strb = cur.strb | (4'(1) << ba[1:0]);
        end
        cur.last = 1'b1;
        exp_q.push_back(cur);
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        logic       exp_busy;
        logic [3:0] exp_rdy;
        logic [3:0] hs;
        beat_t      h;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!rstn) begin
                check("reset_outputs",
                      {req_ready, beat_valid, busy, err, beat_addr, beat_strb, beat_last, beat_ch}, 64'd0);
                exp_q.delete();
                rr_m     = 0;
                err_pend = 1'b0;
                hs_mask  = '0;
            end else begin
                exp_busy = (exp_q.size() != 0);
                exp_rdy  = '0;
                if (!exp_busy && (req_valid != '0)) exp_rdy = 4'(1) << pick(req_valid, rr_m);
                check("req_ready", req_ready, exp_rdy);
                check("beat_valid", beat_valid, exp_busy);
                check("busy", busy, exp_busy);
`ifdef ZERO_LEN_ERR_EN
                check("err", err, err_pend);
`else
                check("err", err, 0);
`endif
                err_pend = 1'b0;
                if (exp_busy && beat_valid) begin
                    h = exp_q[0];
                    check("beat_addr", beat_addr, h.addr);
                    check("beat_strb", beat_strb, h.strb);
                    check("beat_last", beat_last, h.last);
                    check("beat_ch", beat_ch, h.ch);
                    if (beat_ready) begin
                        void'(exp_q.pop_front());
                        beat_cnt++;
                    end
                end
                hs      = req_valid & req_ready;
                hs_mask = hs;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (hs[c]) begin
                        push_beats(c, req_addr[c*ADDR_W +: ADDR_W], req_len[c*LEN_W +: LEN_W]);
                        rr_m = (c + 1) % NUM_CH;
                        if (req_len[c*LEN_W +: LEN_W] == 16'd0) err_pend = 1'b1;
                    end
                end
            end
        end
        check("timeouts", timeouts, 0);
        check("leftover_beats", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic push(input int ch, input logic [31:0] a, input logic [15:0] l);
        req_t r;
        r.a = a;
        r.l = l;
        rq[ch].push_back(r);
    endtask

    // One cycle: retire requests handshaken at the last edge, then drive the queue heads.
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hs_mask[c] && rq[c].size() != 0) void'(rq[c].pop_front());
            if (rq[c].size() != 0) begin
                req_valid[c]                 = 1'b1;
                req_addr[c*ADDR_W +: ADDR_W] = rq[c][0].a;
                req_len[c*LEN_W +: LEN_W]    = rq[c][0].l;
            end else begin
                req_valid[c]                 = 1'b0;
                req_addr[c*ADDR_W +: ADDR_W] = $urandom;
                req_len[c*LEN_W +: LEN_W]    = 16'($urandom);
            end
        end
        beat_ready = br_rand ? ($urandom_range(0, 3) != 0) : br_force;
    endtask

    function automatic logic all_idle();
        for (int c = 0; c < NUM_CH; c++) begin
            if (rq[c].size() != 0) return 1'b0;
        end
        return (exp_q.size() == 0) && !beat_valid && (hs_mask == '0);
    endfunction

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (all_idle()) return;
            step();
        end
        timeouts++;
    endtask

    task automatic wait_beats(input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (beat_cnt >= target) return;
            step();
        end
        timeouts++;
    endtask

    initial begin : stimulus
        int base;
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;

        // Aligned two-beat burst.
        push(0, 32'h0000_0100, 16'd8);
        wait_idle(200);

        // Unaligned start, then address wrap.
        push(2, 32'h0000_0103, 16'd6);
        push(2, 32'hFFFF_FFFC, 16'd8);
        wait_idle(200);

        // Zero-length request; also moves the pointer back to ch0.
        push(3, 32'h0000_0040, 16'd0);
        wait_idle(200);

        // All channels contending, two requests each.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) push(c, 32'h1000 + 32'(16 * c + 64 * r), 16'd4);
        end
        wait_idle(400);

        // Short bursts at the strobe edges.
        push(0, 32'h0000_0203, 16'd1);
        push(1, 32'h0000_0301, 16'd3);
        push(2, 32'h0000_0402, 16'd5);
        wait_idle(200);

        // Stall at beat 2 of 4.
        base = beat_cnt;
        push(1, 32'h0000_2000, 16'd16);
        wait_beats(base + 1, 200);
        beat_ready = 1'b0;
        br_force   = 1'b0;
        step();
        step();
        br_force = 1'b1;
        wait_idle(200);

        // Reset during beat 2 of 4, then contending ch1/ch3 must resolve from ch0.
        base = beat_cnt;
        push(2, 32'h0000_3000, 16'd16);
        wait_beats(base + 1, 200);
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        push(1, 32'h0000_4000, 16'd4);
        push(3, 32'h0000_5000, 16'd4);
        wait_idle(200);

        // Random traffic under random backpressure.
        br_rand = 1'b1;
        repeat (250) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            push($urandom_range(0, NUM_CH - 1), a, 16'($urandom_range(0, 24)));
            repeat ($urandom_range(0, 5)) step();
        end
        wait_idle(20000);
        br_rand = 1'b0;
        repeat (3) step();
        done = 1'b1;
    end

endmodule
